// File: rtl/beat_gen_n.sv
`default_nettype none
// ============================================================================
//  Module   : beat_gen_n
//  Purpose  : Parametrised machine-cycle beat generator. Emits one-hot beat
//             strobes W1..WN per instruction cycle; the cycle length is chosen
//             every beat from short/long (1, NORMAL_BEATS or MAX_BEATS beats).
//             Supports halt/resume on stop, a completed-cycle counter and
//             current-beat reporting.
//  Ports    : t3       - clock, rising edge
//             clr      - synchronous active-high reset
//             go       - start/resume request (IDLE and HALT only)
//             short    - end current cycle after W1 (priority over long)
//             long     - extend current cycle to MAX_BEATS beats
//             stop     - halt after the current cycle (sampled in last beat)
//             ready    - (BEAT_GEN_WAIT_EN only) 0 holds the current beat
//             w        - one-hot beat strobes, bit k is W(k+1)
//             beat_idx - 1-based current beat, 0 when not running
//             cyc_end  - combinational, high in the last beat of a cycle
//             running  - high in RUN
//             cyc_cnt  - completed-cycle counter (wraps)
//  Options  : define BEAT_GEN_WAIT_EN to add the ready wait-state input.
//  Revision : 1.0 - initial release
// ============================================================================
module beat_gen_n #(
    parameter int MAX_BEATS    = 3,
    parameter int NORMAL_BEATS = 2,
    parameter int CNT_W        = 16,
    parameter int AUTO_START   = 1
) (
    input  logic                           t3,
    input  logic                           clr,
    input  logic                           go,
    input  logic                           short,
    input  logic                           long,
    input  logic                           stop,
`ifdef BEAT_GEN_WAIT_EN
    input  logic                           ready,
`endif
    output logic [MAX_BEATS-1:0]           w,
    output logic [$clog2(MAX_BEATS+1)-1:0] beat_idx,
    output logic                           cyc_end,
    output logic                           running,
    output logic [CNT_W-1:0]               cyc_cnt
);

    localparam int c_idx_w = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    localparam logic                 c_auto     = (AUTO_START != 0);
    localparam logic [MAX_BEATS-1:0] c_w1       = {{(MAX_BEATS-1){1'b0}}, 1'b1};
    localparam logic [c_idx_w-1:0]   c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0]   c_lim_max  = c_idx_w'(MAX_BEATS);
    localparam logic [c_idx_w-1:0]   c_lim_norm = c_idx_w'(NORMAL_BEATS);
    localparam logic [CNT_W-1:0]     c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    generate
        if (MAX_BEATS < 2 || MAX_BEATS > 8) begin : g_bad_max_beats
            $error("beat_gen_n: MAX_BEATS must be in 2..8");
        end
        if (NORMAL_BEATS < 1 || NORMAL_BEATS > MAX_BEATS) begin : g_bad_normal_beats
            $error("beat_gen_n: NORMAL_BEATS must be in 1..MAX_BEATS");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [MAX_BEATS-1:0] r_w;
    logic [c_idx_w-1:0]   r_beat_idx;
    logic                 r_running;
    logic [CNT_W-1:0]     r_cyc_cnt;

    logic [c_idx_w-1:0]   w_limit;
    logic                 w_cyc_end;
    logic                 w_ready;

`ifdef BEAT_GEN_WAIT_EN
    assign w_ready = ready;
`else
    assign w_ready = 1'b1;
`endif

    // Cycle length is re-evaluated every beat so a late short/long request
    // still shortens or extends the cycle currently in progress.
    always_comb begin
        w_limit = c_lim_norm;
        if (short) begin
            w_limit = c_idx_one;
        end else if (long) begin
            w_limit = c_lim_max;
        end
    end

    // '>=' rather than '==': if long drops after the cycle already passed
    // NORMAL_BEATS, the current beat is simply treated as the last one.
    assign w_cyc_end = r_running && (r_beat_idx >= w_limit);

    always_ff @(posedge t3) begin
        if (clr) begin
            r_state    <= c_st_idle;
            r_w        <= '0;
            r_beat_idx <= '0;
            r_running  <= 1'b0;
            r_cyc_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (go || c_auto) begin
                        r_state    <= c_st_run;
                        r_w        <= c_w1;
                        r_beat_idx <= c_idx_one;
                        r_running  <= 1'b1;
                    end
                end
                c_st_run: begin
                    if (w_ready) begin
                        if (w_cyc_end) begin
                            r_cyc_cnt <= r_cyc_cnt + c_cnt_one;
                            if (stop) begin
                                r_state    <= c_st_halt;
                                r_w        <= '0;
                                r_beat_idx <= '0;
                                r_running  <= 1'b0;
                            end else begin
                                // back-to-back cycles: no idle beat in between
                                r_w        <= c_w1;
                                r_beat_idx <= c_idx_one;
                            end
                        end else begin
                            r_w        <= {r_w[MAX_BEATS-2:0], 1'b0};
                            r_beat_idx <= r_beat_idx + c_idx_one;
                        end
                    end
                end
                c_st_halt: begin
                    if (go) begin
                        r_state    <= c_st_run;
                        r_w        <= c_w1;
                        r_beat_idx <= c_idx_one;
                        r_running  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_st_idle;
                    r_w        <= '0;
                    r_beat_idx <= '0;
                    r_running  <= 1'b0;
                end
            endcase
        end
    end

    assign w        = r_w;
    assign beat_idx = r_beat_idx;
    assign running  = r_running;
    assign cyc_cnt  = r_cyc_cnt;
    assign cyc_end  = w_cyc_end;

endmodule
`default_nettype wire

// File: tb/tb_beat_gen_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beat_gen_n
//  Purpose  : Self-checking bench for beat_gen_n. Two instances: u_dut1 with
//             default parameters and u_dut2 (MAX_BEATS=4, NORMAL_BEATS=3,
//             CNT_W=2, AUTO_START=0). Expected values come from a cycle-level
//             behavioural model of the beat generator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_beat_gen_n;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        int mode;
        int beat;
        int cnt;
    } mdl_t;

    logic t3;

    logic       clr1, go1, sh1, lg1, st1, rd1;
    logic [2:0] w1;
    logic [1:0] idx1;
    logic       ce1, run1;
    logic [15:0] cnt1;

    logic       clr2, go2, sh2, lg2, st2, rd2;
    logic [3:0] w2;
    logic [2:0] idx2;
    logic       ce2, run2;
    logic [1:0] cnt2;

    mdl_t m1, m2;
    int   n_tests = 0;
    int   n_fail  = 0;

    beat_gen_n u_dut1 (
        .t3(t3), .clr(clr1), .go(go1), .short(sh1), .long(lg1), .stop(st1),
`ifdef BEAT_GEN_WAIT_EN
        .ready(rd1),
`endif
        .w(w1), .beat_idx(idx1), .cyc_end(ce1), .running(run1), .cyc_cnt(cnt1)
    );

    beat_gen_n #(.MAX_BEATS(4), .NORMAL_BEATS(3), .CNT_W(2), .AUTO_START(0)) u_dut2 (
        .t3(t3), .clr(clr2), .go(go2), .short(sh2), .long(lg2), .stop(st2),
`ifdef BEAT_GEN_WAIT_EN
        .ready(rd2),
`endif
        .w(w2), .beat_idx(idx2), .cyc_end(ce2), .running(run2), .cyc_cnt(cnt2)
    );

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    // ---------------- behavioural model ----------------
    function automatic int lim(input bit sh, input bit lg, input int maxb, input int normb);
        return sh ? 1 : (lg ? maxb : normb);
    endfunction

    function automatic bit mend(input mdl_t s, input bit sh, input bit lg, input int maxb, input int normb);
        return (s.mode == M_RUN) && (s.beat >= lim(sh, lg, maxb, normb));
    endfunction

    function automatic int fw(input mdl_t s);
        return (s.mode == M_RUN) ? (1 << (s.beat - 1)) : 0;
    endfunction

    function automatic mdl_t mnext(input mdl_t s, input bit clr, input bit go, input bit sh,
                                   input bit lg, input bit stp, input bit rdy, input int maxb,
                                   input int normb, input int cntw, input bit autos);
        mdl_t n;
        n = s;
        if (clr) begin
            n.mode = M_IDLE; n.beat = 0; n.cnt = 0;
        end else if (s.mode == M_IDLE) begin
            if (go || autos) begin n.mode = M_RUN; n.beat = 1; end
        end else if (s.mode == M_HALT) begin
            if (go) begin n.mode = M_RUN; n.beat = 1; end
        end else if (rdy) begin
            if (mend(s, sh, lg, maxb, normb)) begin
                n.cnt = (s.cnt + 1) % (1 << cntw);
                if (stp) begin n.mode = M_HALT; n.beat = 0; end
                else n.beat = 1;
            end else begin
                n.beat = s.beat + 1;
            end
        end
        return n;
    endfunction

    // Advance one clock edge; model follows with the inputs present at the edge.
    task automatic advance();
        mdl_t n1, n2;
        n1 = mnext(m1, clr1, go1, sh1, lg1, st1, rd1, 3, 2, 16, 1'b1);
        n2 = mnext(m2, clr2, go2, sh2, lg2, st2, rd2, 4, 3, 2, 1'b0);
        @(posedge t3);
        #1;
        m1 = n1;
        m2 = n2;
    endtask

    // Run dut1 with normal cycles until the model says it sits at W1.
    task automatic sync_w1(output bit ok);
        sh1 = 0; lg1 = 0; st1 = 0; go1 = 0; rd1 = 1;
        for (int k = 0; k < 10 && !(m1.mode == M_RUN && m1.beat == 1); k++) advance();
        ok = (m1.mode == M_RUN && m1.beat == 1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int seq [6] = '{1, 2, 1, 2, 1, 2};
        clr1 = 1; go1 = 0; sh1 = 0; lg1 = 0; st1 = 0; rd1 = 1;
        clr2 = 1; go2 = 0; sh2 = 0; lg2 = 0; st2 = 0; rd2 = 1;
        m1 = '{M_IDLE, 0, 0}; m2 = '{M_IDLE, 0, 0};
        advance(); advance();
        n_tests++; if (w1 !== 3'b000) begin n_fail++; $display("FAIL reset_w: got %b expected 000", w1); end
        n_tests++; if (idx1 !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", idx1); end
        n_tests++; if (run1 !== 1'b0 || ce1 !== 1'b0) begin n_fail++; $display("FAIL reset_run: got run=%b end=%b expected 0/0", run1, ce1); end
        n_tests++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt1); end
        clr1 = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++; if (ce1 !== mend(m1, sh1, lg1, 3, 2)) begin n_fail++; $display("FAIL startup_end[%0d]: got %b expected %b", i, ce1, mend(m1, sh1, lg1, 3, 2)); end
            advance();
            n_tests++; if (w1 !== 3'(seq[i]) || w1 !== 3'(fw(m1))) begin n_fail++; $display("FAIL startup_w[%0d]: got %b expected %b", i, w1, 3'(seq[i])); end
            if (i == 2) begin
                n_tests++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL startup_cnt: got %0d expected 1", cnt1); end
            end
        end
    endtask

    task automatic test_short();
        logic [15:0] prev;
        sh1 = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (ce1 !== 1'b1) begin n_fail++; $display("FAIL short_end[%0d]: got %b expected 1", i, ce1); end
            prev = cnt1;
            advance();
            n_tests++; if (w1 !== 3'b001 || idx1 !== 2'd1) begin n_fail++; $display("FAIL short_w[%0d]: got %b/%0d expected 001/1", i, w1, idx1); end
            n_tests++; if (cnt1 !== prev + 16'd1 || cnt1 !== 16'(m1.cnt)) begin n_fail++; $display("FAIL short_cnt[%0d]: got %0d expected %0d", i, cnt1, m1.cnt); end
        end
        sh1 = 0;
    endtask

    task automatic test_long();
        bit ok;
        sync_w1(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL long_sync: got no W1 expected W1 within 10 edges"); end
        #1;
        n_tests++; if (ce1 !== 1'b0) begin n_fail++; $display("FAIL long_end_w1: got %b expected 0", ce1); end
        advance();
        lg1 = 1; #1;
        n_tests++; if (w1 !== 3'b010 || ce1 !== 1'b0) begin n_fail++; $display("FAIL long_w2: got w=%b end=%b expected 010/0", w1, ce1); end
        advance(); #1;
        n_tests++; if (w1 !== 3'b100 || idx1 !== 2'd3 || ce1 !== 1'b1) begin n_fail++; $display("FAIL long_w3: got w=%b idx=%0d end=%b expected 100/3/1", w1, idx1, ce1); end
        advance();
        n_tests++; if (w1 !== 3'b001) begin n_fail++; $display("FAIL long_wrap: got %b expected 001", w1); end
        // long dropped while in W3: beat 3 > limit 2 still ends the cycle
        advance();
        advance();
        lg1 = 0; #1;
        n_tests++; if (w1 !== 3'b100 || ce1 !== 1'b1) begin n_fail++; $display("FAIL long_drop: got w=%b end=%b expected 100/1", w1, ce1); end
        advance();
        n_tests++; if (w1 !== 3'b001 || cnt1 !== 16'(m1.cnt)) begin n_fail++; $display("FAIL long_drop_next: got w=%b cnt=%0d expected 001/%0d", w1, cnt1, m1.cnt); end
    endtask

    task automatic test_stop();
        bit ok;
        sync_w1(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stop_sync: got no W1 expected W1 within 10 edges"); end
        st1 = 1;
        advance();
        n_tests++; if (w1 !== 3'b010 || run1 !== 1'b1) begin n_fail++; $display("FAIL stop_w1_ignored: got w=%b run=%b expected 010/1", w1, run1); end
        advance();
        n_tests++; if (w1 !== 3'b000 || run1 !== 1'b0 || idx1 !== 2'd0) begin n_fail++; $display("FAIL stop_halt: got w=%b run=%b idx=%0d expected 000/0/0", w1, run1, idx1); end
        st1 = 0;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_tests++; if (w1 !== 3'b000 || run1 !== 1'b0) begin n_fail++; $display("FAIL stop_stay[%0d]: got w=%b run=%b expected 000/0", i, w1, run1); end
        end
        go1 = 1;
        advance();
        go1 = 0;
        n_tests++; if (w1 !== 3'b001 || run1 !== 1'b1) begin n_fail++; $display("FAIL stop_resume: got w=%b run=%b expected 001/1", w1, run1); end
        advance();
        st1 = 1; go1 = 1;
        advance();
        st1 = 0; go1 = 0;
        n_tests++; if (w1 !== 3'b000 || run1 !== 1'b0) begin n_fail++; $display("FAIL stop_go_same: got w=%b run=%b expected 000/0", w1, run1); end
        advance(); advance();
        n_tests++; if (run1 !== 1'b0) begin n_fail++; $display("FAIL stop_go_needs_fresh: got run=%b expected 0", run1); end
        go1 = 1;
        advance();
        n_tests++; if (w1 !== 3'b001) begin n_fail++; $display("FAIL stop_hold_go_a: got %b expected 001", w1); end
        advance();
        go1 = 0;
        n_tests++; if (w1 !== 3'b010) begin n_fail++; $display("FAIL stop_hold_go_b: got %b expected 010", w1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr1 = ($urandom_range(49) == 0); clr2 = ($urandom_range(49) == 0);
            go1 = ($urandom_range(3) == 0);   go2 = ($urandom_range(3) == 0);
            sh1 = ($urandom_range(4) == 0);   sh2 = ($urandom_range(4) == 0);
            lg1 = ($urandom_range(2) == 0);   lg2 = ($urandom_range(2) == 0);
            st1 = ($urandom_range(5) == 0);   st2 = ($urandom_range(5) == 0);
`ifdef BEAT_GEN_WAIT_EN
            rd1 = ($urandom_range(3) != 0);   rd2 = ($urandom_range(3) != 0);
`endif
            #1;
            n_tests++; if (ce1 !== mend(m1, sh1, lg1, 3, 2) || ce2 !== mend(m2, sh2, lg2, 4, 3)) begin
                n_fail++; $display("FAIL rand_end[%0d]: got %b/%b expected %b/%b", i, ce1, ce2, mend(m1, sh1, lg1, 3, 2), mend(m2, sh2, lg2, 4, 3));
            end
            advance();
            n_tests++; if (w1 !== 3'(fw(m1)) || idx1 !== 2'(m1.beat) || run1 !== (m1.mode == M_RUN) || cnt1 !== 16'(m1.cnt)) begin
                n_fail++; $display("FAIL rand_dut1[%0d]: got w=%b idx=%0d run=%b cnt=%0d expected %b/%0d/%b/%0d", i, w1, idx1, run1, cnt1, 3'(fw(m1)), m1.beat, (m1.mode == M_RUN), m1.cnt);
            end
            n_tests++; if (w2 !== 4'(fw(m2)) || idx2 !== 3'(m2.beat) || run2 !== (m2.mode == M_RUN) || cnt2 !== 2'(m2.cnt)) begin
                n_fail++; $display("FAIL rand_dut2[%0d]: got w=%b idx=%0d run=%b cnt=%0d expected %b/%0d/%b/%0d", i, w2, idx2, run2, cnt2, 4'(fw(m2)), m2.beat, (m2.mode == M_RUN), m2.cnt);
            end
        end
        clr1 = 0; go1 = 0; sh1 = 0; lg1 = 0; st1 = 0; rd1 = 1;
        clr2 = 0; go2 = 0; sh2 = 0; lg2 = 0; st2 = 0; rd2 = 1;
    endtask

    task automatic test_cnt_wrap();
        int cseq [5] = '{1, 2, 3, 0, 1};
        clr2 = 1; go2 = 0; sh2 = 0; lg2 = 0; st2 = 0; rd2 = 1;
        advance();
        clr2 = 0;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_tests++; if (run2 !== 1'b0 || w2 !== 4'b0000) begin n_fail++; $display("FAIL noauto_idle[%0d]: got run=%b w=%b expected 0/0000", i, run2, w2); end
        end
        go2 = 1;
        advance();
        go2 = 0;
        n_tests++; if (w2 !== 4'b0001 || idx2 !== 3'd1) begin n_fail++; $display("FAIL noauto_go: got w=%b idx=%0d expected 0001/1", w2, idx2); end
        for (int k = 1; k <= 15; k++) begin
            advance();
            if (k % 3 == 0) begin
                n_tests++; if (cnt2 !== 2'(cseq[k/3-1]) || w2 !== 4'b0001) begin n_fail++; $display("FAIL wrap_cnt[%0d]: got cnt=%0d w=%b expected %0d/0001", k/3, cnt2, w2, cseq[k/3-1]); end
            end
        end
        advance();
        n_tests++; if (w2 !== 4'b0010) begin n_fail++; $display("FAIL wrap_w2: got %b expected 0010", w2); end
        clr2 = 1;
        advance();
        clr2 = 0;
        n_tests++; if (w2 !== 4'b0000 || idx2 !== 3'd0 || run2 !== 1'b0 || cnt2 !== 2'd0) begin
            n_fail++; $display("FAIL midcycle_clr: got w=%b idx=%0d run=%b cnt=%0d expected 0000/0/0/0", w2, idx2, run2, cnt2);
        end
    endtask

`ifdef BEAT_GEN_WAIT_EN
    task automatic test_wait();
        bit ok;
        logic [15:0] prev;
        sync_w1(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wait_sync: got no W1 expected W1 within 10 edges"); end
        advance();
        prev = cnt1;
        rd1 = 0; st1 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (ce1 !== 1'b1) begin n_fail++; $display("FAIL wait_end[%0d]: got %b expected 1", i, ce1); end
            advance();
            n_tests++; if (w1 !== 3'b010 || cnt1 !== prev || run1 !== 1'b1) begin n_fail++; $display("FAIL wait_hold[%0d]: got w=%b cnt=%0d run=%b expected 010/%0d/1", i, w1, cnt1, run1, prev); end
        end
        rd1 = 1; st1 = 0;
        advance();
        n_tests++; if (w1 !== 3'b001 || cnt1 !== prev + 16'd1) begin n_fail++; $display("FAIL wait_release: got w=%b cnt=%0d expected 001/%0d", w1, cnt1, prev + 16'd1); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_short();
        test_long();
        test_stop();
        test_random();
        test_cnt_wrap();
`ifdef BEAT_GEN_WAIT_EN
        test_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
